// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input longint sys_clk, input longint baud_rate,
                                    input longint oversample);
        longint den;
        den = baud_rate * oversample;
        return int'((sys_clk + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Ready/valid word port between the receiver and the RX FIFO.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic                 valid;
    logic                 ready;
    logic [DATA_BITS-1:0] data_out;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun;

    modport master (
        output valid, data_out, parity_err, frame_err, break_det, overrun,
        input  ready
    );

    modport slave (
        input  valid, data_out, parity_err, frame_err, break_det, overrun,
        output ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider; restart realigns the phase to a start edge.
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    // Count 0..DIV-1, wrapping after the tick.
    always_ff @(posedge clk) begin
        if (reset || restart)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority vote and per-word status flags.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int BAUD_RATE   = 9600,
    parameter int SYS_CLK     = 100_000_000,
    parameter int OVERSAMPLE  = 16,
    parameter int STOP_BITS   = 1,
    parameter int HAS_PARITY  = 0,
    parameter int PARITY_EVEN = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sig,
    uart_rx_os_if.master rx
);
    localparam int DIV = calc_div(SYS_CLK, BAUD_RATE, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    if (DIV < 2) begin : g_div_chk
        $error("uart_rx_os: clock divider must be at least 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
        $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
        $error("uart_rx_os: DATA_BITS must be 5..9");
    end

    logic                 sync1, sync2, prev;
    logic                 tick, start_edge, decide, bit_end;
    rx_state_t            state;
    logic [SW-1:0]        s;
    logic                 v_lo, v_mid, vote;
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 fe_acc, pe_acc, zero_acc;
    logic                 done, done_brk, done_fe, hs;

    // Two-stage synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= sig;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Only a true 1->0 transition starts a frame, never a held-low line.
    assign start_edge = (state == IDLE) && prev && !sync2;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (start_edge),
        .tick    (tick)
    );

    assign decide  = tick && (s == S_HI);
    assign bit_end = tick && (s == S_LAST);
    assign vote    = (v_lo & v_mid) | (v_lo & sync2) | (v_mid & sync2);

    // Frame ends at the last stop bit's decision point so the next start edge is caught.
    assign done     = (state == STOP) && decide && (stop_cnt == STOP_LAST);
    assign done_brk = zero_acc & ~vote;
    assign done_fe  = fe_acc | ~vote;
    assign hs       = rx.valid & rx.ready;

    // Sample counter, mid-bit vote capture and the frame FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            s        <= '0;
            v_lo     <= 1'b0;
            v_mid    <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            fe_acc   <= 1'b0;
            pe_acc   <= 1'b0;
            zero_acc <= 1'b0;
        end else begin
            if (start_edge)
                s <= '0;
            else if (tick)
                s <= (s == S_LAST) ? '0 : s + 1'b1;

            if (tick && s == S_LO)  v_lo  <= sync2;
            if (tick && s == S_MID) v_mid <= sync2;

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state    <= START;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        fe_acc   <= 1'b0;
                        pe_acc   <= 1'b0;
                        zero_acc <= 1'b1;
                    end
                end
                START: begin
                    if (decide && vote)
                        state <= IDLE;
                    else if (bit_end)
                        state <= DATA;
                end
                DATA: begin
                    if (decide) begin
                        shreg    <= {vote, shreg[DATA_BITS-1:1]};
                        zero_acc <= zero_acc & ~vote;
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                    if (bit_end && bit_cnt == 4'(DATA_BITS))
                        state <= (HAS_PARITY != 0) ? PARITY : STOP;
                end
                PARITY: begin
                    if (decide) begin
                        pe_acc   <= (vote != ((^shreg) ^ (PARITY_EVEN == 0)));
                        zero_acc <= zero_acc & ~vote;
                    end
                    if (bit_end)
                        state <= STOP;
                end
                STOP: begin
                    if (decide) begin
                        if (!vote)
                            fe_acc <= 1'b1;
                        if (stop_cnt == STOP_LAST)
                            state <= done_brk ? BRK_WAIT : IDLE;
                        else
                            stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                BRK_WAIT: begin
                    if (sync2)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output holding register: load on completion, flag overrun if the slot is busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx.valid      <= 1'b0;
            rx.data_out   <= '0;
            rx.parity_err <= 1'b0;
            rx.frame_err  <= 1'b0;
            rx.break_det  <= 1'b0;
            rx.overrun    <= 1'b0;
        end else if (done && (!rx.valid || hs)) begin
            rx.valid      <= 1'b1;
            rx.data_out   <= done_brk ? '0 : shreg;
            rx.parity_err <= (HAS_PARITY != 0) && pe_acc;
            rx.frame_err  <= done_fe;
            rx.break_det  <= done_brk;
            rx.overrun    <= 1'b0;
        end else if (done) begin
            rx.overrun <= 1'b1;
        end else if (hs) begin
            rx.valid   <= 1'b0;
            rx.overrun <= 1'b0;
        end
    end
endmodule
